// File: rtl/writeback_regfile_pkg.sv
// Shared CPU definitions: opcode encodings, datapath widths and the register-writing predicate.
// Decode hazard logic uses the same writes_reg() helper as the writeback stage.
package writeback_regfile_pkg;

  localparam int DATA_W    = 16;
  localparam int NREGS     = 8;
  localparam int REG_IDX_W = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  function automatic logic writes_reg(input logic [2:0] opcode);
    return (opcode != OP_SW) && (opcode != OP_BEQ);
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Memory-stage slot, decode read ports and commit/status outputs of the writeback stage.
// The master side drives the slot and read addresses; the slave side is the writeback stage.
interface writeback_regfile_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 3
);
  logic              bubble_in;
  logic [2:0]        opcode_in;
  logic [IDX_W-1:0]  tgt_in;
  logic [DATA_W-1:0] result_in;
  logic [DATA_W-1:0] mem_rdata;
  logic              halt_in;
  logic [IDX_W-1:0]  raddr0;
  logic [IDX_W-1:0]  raddr1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              wb_en;
  logic [IDX_W-1:0]  wb_tgt;
  logic [DATA_W-1:0] wb_data;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    output bubble_in, opcode_in, tgt_in, result_in, mem_rdata, halt_in, raddr0, raddr1,
    input  rdata0, rdata1, wb_en, wb_tgt, wb_data, halted, retired
  );

  modport slave (
    input  bubble_in, opcode_in, tgt_in, result_in, mem_rdata, halt_in, raddr0, raddr1,
    output rdata0, rdata1, wb_en, wb_tgt, wb_data, halted, retired
  );
endinterface

// File: rtl/writeback_regfile_regfile_2r1w.sv
// NREGS x DATA_W register file, r0 hardwired to zero, two combinational read ports with
// write-through bypass so a commit is visible to readers in the same cycle.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr0_i,
  input  logic [IDX_W-1:0]  raddr1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);

  logic [DATA_W-1:0] regs_q [1:NREGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] ra);
    if (ra == '0) begin
      return '0;
    end else if (we_i && (ra == waddr_i)) begin
      return wdata_i;
    end
    return regs_q[ra];
  endfunction

  assign rdata0_o = read_port(raddr0_i);
  assign rdata1_o = read_port(raddr1_i);

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: commits memory-stage results to the register file, exposes the commit bus,
// latches a sticky halt and counts retired instructions. Zero-latency commit, no backpressure.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = writeback_regfile_pkg::DATA_W,
  parameter int NREGS  = writeback_regfile_pkg::NREGS,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  writeback_regfile_if.slave  bus
);

  localparam int IDX_W = $clog2(NREGS);

  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             slot_vld;
  logic             wb_en;
  logic [DATA_W-1:0] wb_data;

  // Bubble gates everything first so X on the other slot fields cannot leak into state.
  assign slot_vld = !bus.bubble_in && !halted_q;
  assign wb_en    = slot_vld && !bus.halt_in && writes_reg(bus.opcode_in) && (bus.tgt_in != '0);
  assign wb_data  = (bus.opcode_in == OP_LW) ? bus.mem_rdata : bus.result_in;

  always_comb begin
    halted_d  = halted_q;
    retired_d = retired_q;
    if (slot_vld && bus.halt_in) begin
      halted_d = 1'b1;
    end
    if (slot_vld && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en),
    .waddr_i  (bus.tgt_in),
    .wdata_i  (wb_data),
    .raddr0_i (bus.raddr0),
    .raddr1_i (bus.raddr1),
    .rdata0_o (bus.rdata0),
    .rdata1_o (bus.rdata1)
  );

  assign bus.wb_en   = wb_en;
  assign bus.wb_tgt  = bus.tgt_in;
  assign bus.wb_data = wb_data;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized checks of the writeback stage against an array-based model;
// a second, 4-bit-counter instance exercises retired-count saturation.
module tb_writeback_regfile;

  logic clk = 1'b0;
  logic rst;
  int   ncmp  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  writeback_regfile_if #(.DATA_W(16), .CNT_W(32), .IDX_W(3)) bus ();
  writeback_regfile_if #(.DATA_W(16), .CNT_W(4),  .IDX_W(3)) bus4 ();

  writeback_regfile #(.DATA_W(16), .NREGS(8), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  writeback_regfile #(.DATA_W(16), .NREGS(8), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Architectural model
  logic [15:0] mregs [8];
  logic        mhalted;
  logic [31:0] mretired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mhalted  = 1'b0;
    mretired = 32'd0;
  endtask

  // Drive one slot just after a negedge, check combinational and registered outputs,
  // then let the posedge commit and advance the model.
  task automatic step(input logic bub, input logic [2:0] op, input logic [2:0] tgt,
                      input logic [15:0] res, input logic [15:0] mrd, input logic hlt,
                      input logic [2:0] ra0, input logic [2:0] ra1, input string tag);
    logic        v, en;
    logic [15:0] d, e0, e1;
    bus.bubble_in = bub;  bus.opcode_in = op;   bus.tgt_in = tgt;
    bus.result_in = res;  bus.mem_rdata = mrd;  bus.halt_in = hlt;
    bus.raddr0    = ra0;  bus.raddr1    = ra1;
    #1;
    v  = !bub && !mhalted;
    en = v && !hlt && (op != 3'd4) && (op != 3'd6) && (tgt != 3'd0);
    d  = (op == 3'd5) ? mrd : res;
    e0 = (ra0 == 0) ? 16'h0 : ((en && ra0 == tgt) ? d : mregs[ra0]);
    e1 = (ra1 == 0) ? 16'h0 : ((en && ra1 == tgt) ? d : mregs[ra1]);
    chk({tag, ".wb_en"},   {31'd0, bus.wb_en}, {31'd0, en});
    if (en) begin
      chk({tag, ".wb_data"}, {16'd0, bus.wb_data}, {16'd0, d});
      chk({tag, ".wb_tgt"},  {29'd0, bus.wb_tgt},  {29'd0, tgt});
    end
    chk({tag, ".rdata0"},  {16'd0, bus.rdata0}, {16'd0, e0});
    chk({tag, ".rdata1"},  {16'd0, bus.rdata1}, {16'd0, e1});
    chk({tag, ".halted"},  {31'd0, bus.halted}, {31'd0, mhalted});
    chk({tag, ".retired"}, bus.retired, mretired);
    @(posedge clk);
    if (en) mregs[tgt] = d;
    if (v && hlt) mhalted = 1'b1;
    if (v) mretired = mretired + 1;
    @(negedge clk);
  endtask

  task automatic idle_bus4();
    bus4.bubble_in = 1'b1; bus4.opcode_in = 3'd4; bus4.tgt_in = 3'd0;
    bus4.result_in = 16'h0; bus4.mem_rdata = 16'h0; bus4.halt_in = 1'b0;
    bus4.raddr0 = 3'd0; bus4.raddr1 = 3'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle_bus4();
    bus.bubble_in = 1'b1; bus.opcode_in = 3'd0; bus.tgt_in = 3'd0;
    bus.result_in = 16'h0; bus.mem_rdata = 16'h0; bus.halt_in = 1'b0;
    bus.raddr0 = 3'd0; bus.raddr1 = 3'd0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run: r3 written, then async reset clears everything before any edge
    step(0, 3'd1, 3'd3, 16'h1234, 16'h0, 0, 3'd3, 3'd0, "r3_write");
    step(1, 3'd0, 3'd0, 16'h0,    16'h0, 0, 3'd3, 3'd3, "r3_read");
    rst = 1'b1;
    #1;
    chk("reset.rdata0",  {16'd0, bus.rdata0}, 32'h0);
    chk("reset.halted",  {31'd0, bus.halted}, 32'h0);
    chk("reset.retired", bus.retired, 32'h0);
    model_reset();
    #1;
    rst = 1'b0;

    // ADDI bypass then storage read
    step(0, 3'd1, 3'd3, 16'h00FF, 16'h0, 0, 3'd3, 3'd0, "addi_bypass");
    step(1, 3'd0, 3'd0, 16'h0,    16'h0, 0, 3'd3, 3'd3, "addi_stored");
    chk("addi.retired", bus.retired, 32'd1);

    // LW picks memory data; SW/BEQ never write
    step(0, 3'd5, 3'd5, 16'h0040, 16'hBEEF, 0, 3'd5, 3'd5, "lw");
    step(0, 3'd4, 3'd5, 16'h1111, 16'h2222, 0, 3'd5, 3'd0, "sw");
    step(0, 3'd6, 3'd5, 16'h1111, 16'h2222, 0, 3'd0, 3'd5, "beq");
    step(1, 3'd0, 3'd0, 16'h0,    16'h0,    0, 3'd5, 3'd3, "lw_chk");
    chk("lw.r5", {16'd0, bus.rdata0}, 32'h0000BEEF);

    // r0 writes dropped; bubbles suppress everything
    step(0, 3'd0, 3'd0, 16'hFFFF, 16'h0, 0, 3'd0, 3'd0, "add_r0");
    step(1, 3'd0, 3'd2, 16'h5555, 16'h0, 0, 3'd2, 3'd0, "bubble");
    step(1, 3'd0, 3'd2, 16'h0,    16'h0, 1, 3'd2, 3'd0, "bubble_halt");

    // Randomized traffic, no halts
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 16'($urandom),
           16'($urandom), 0, 3'($urandom), 3'($urandom), "rand");
    end

    // Halt then everything ignored
    step(0, 3'd0, 3'd1, 16'h0009, 16'h0, 1, 3'd1, 3'd0, "halt");
    chk("halt.halted", {31'd0, bus.halted}, 32'd1);
    step(0, 3'd0, 3'd1, 16'h0007, 16'h0, 0, 3'd1, 3'd1, "post_halt");
    step(0, 3'd1, 3'd6, 16'h0008, 16'h0, 0, 3'd6, 3'd1, "post_halt2");

    // Counter saturation on the 4-bit instance
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    bus.bubble_in = 1'b1;
    bus4.bubble_in = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n >= 14) chk("sat.retired", {28'd0, bus4.retired}, (n > 15) ? 32'd15 : 32'(n));
    end
    idle_bus4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
